// File: rtl/io_defs_pkg.sv
// Shared MMIO definitions for the memory-mapped IO window: register
// addresses, the empty-read sentinel and status word bit positions.
package io_defs;

    localparam logic [31:0] OUT_AVAIL    = 32'h8000_0000;
    localparam logic [31:0] OUT_DATA     = 32'h8000_0004;
    localparam logic [31:0] IN_STATUS    = 32'h8000_0008;
    localparam logic [31:0] IN_DATA      = 32'h8000_000C;

    localparam logic [31:0] EMPTY_WORD   = 32'hFFFF_FFFF;
    localparam int          OVERFLOW_BIT = 31;

endpackage

// File: rtl/mmio_input_port_fifo.sv
// Circular byte FIFO with qualified push/pop, combinational head byte,
// occupancy count and full/empty flags.
module byte_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[head_q];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) begin
            mem_d[tail_q] = wr_data;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop_ok) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped input port: an external producer pushes bytes, the CPU polls
// STATUS and pops bytes by loading from DATA.
module mmio_input_port
    import io_defs::*;
#(
    parameter int          INPUT_BUFFER_BYTE_SIZE = 32,
    parameter logic [31:0] BASE_ADDR              = IN_STATUS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_read,
    input  logic        read_en,
    output logic [31:0] read_data,
    input  logic        write_en,
    input  logic [31:0] addr_write,
    input  logic        io_input_en,
    input  logic [7:0]  io_input_data,
    output logic        io_input_ready,
    output logic        io_overflow,
    output logic [31:0] io_buffer_size_used
);

    localparam int          CNT_W     = $clog2(INPUT_BUFFER_BYTE_SIZE) + 1;
    localparam logic [31:0] DATA_ADDR = BASE_ADDR + 32'd4;

    logic [7:0]       head_byte;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_fire;
    logic             overflow_q, overflow_d;

    assign pop_fire       = read_en && (addr_read == DATA_ADDR) && !fifo_empty;
    assign io_input_ready = !fifo_full || pop_fire;

    byte_fifo #(
        .DEPTH (INPUT_BUFFER_BYTE_SIZE)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (io_input_en),
        .pop       (read_en && (addr_read == DATA_ADDR)),
        .wr_data   (io_input_data),
        .head_data (head_byte),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Clear first so a coincident dropped push still leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (write_en && (addr_write == BASE_ADDR)) begin
            overflow_d = 1'b0;
        end
        if (io_input_en && !io_input_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        read_data = '0;
        if (addr_read == BASE_ADDR) begin
            read_data[15:0]         = 16'(fifo_count);
            read_data[OVERFLOW_BIT] = overflow_q;
        end else if (addr_read == DATA_ADDR) begin
            read_data = fifo_empty ? EMPTY_WORD : {24'b0, head_byte};
        end
    end

    assign io_overflow         = overflow_q;
    assign io_buffer_size_used = 32'(fifo_count);

endmodule
